// File: rtl/scr1_fprf_pkg.sv
// scr1_fprf_pkg: shared constants and types for the FP register file
package scr1_fprf_pkg;
  localparam int FPRF_ADDR_W  = 5;
  localparam int FPRF_FLEN    = 32;
  localparam int FPRF_NWR     = 2;
  localparam int FPRF_WP_FAST = 0;
  localparam int FPRF_WP_LONG = FPRF_NWR - 1;
  typedef logic [FPRF_ADDR_W-1:0] fprf_addr_t;
  typedef logic [FPRF_FLEN-1:0]   fprf_data_t;
endpackage

// File: rtl/scr1_pipe_fprf_scb.sv
// scr1_pipe_fprf_scb: per-register pending/owner scoreboard with reserve, write-back clear and flush
module scr1_pipe_fprf_scb #(
  parameter int NREGS = 32,
  parameter int NWR   = 2,
  parameter int AW    = 5,
  parameter int PW    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    resv_vld_i,
  input  logic [AW-1:0]           resv_addr_i,
  input  logic [PW-1:0]           resv_port_i,
  input  logic [NWR-1:0]          wr_vld_i,
  input  logic [NWR-1:0][AW-1:0]  wr_addr_i,
  input  logic                    flush_i,
  output logic                    resv_rdy_o,
  output logic [NREGS-1:0]        pend_o,
  output logic [NREGS-1:0]        clr_o,
  output logic                    busy_o
);
  logic [NREGS-1:0]          pend_q, pend_d;
  logic [NREGS-1:0][PW-1:0]  own_q, own_d;
  assign resv_rdy_o = !pend_q[resv_addr_i] && !flush_i;
  assign busy_o     = |pend_q;
  assign pend_o     = pend_q;
  // only the owning port retires a pending register
  always_comb begin
    clr_o  = '0;
    pend_d = '0;
    own_d  = own_q;
    for (int r = 0; r < NREGS; r++) begin
      for (int p = 0; p < NWR; p++)
        if (wr_vld_i[p] && wr_addr_i[p] == AW'(r) && own_q[r] == PW'(p)) clr_o[r] = pend_q[r];
      if (resv_vld_i && resv_rdy_o && resv_addr_i == AW'(r)) begin
        pend_d[r] = 1'b1;
        own_d[r]  = resv_port_i;
      end else begin
        pend_d[r] = pend_q[r] && !clr_o[r] && !flush_i;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend_q <= '0;
      own_q  <= '0;
    end else begin
      pend_q <= pend_d;
      own_q  <= own_d;
    end
endmodule

// File: rtl/scr1_pipe_fprf_mp.sv
// scr1_pipe_fprf_mp: multi-port FP register file with write-back scoreboard and optional write bypass
import scr1_fprf_pkg::*;
module scr1_pipe_fprf_mp #(
  parameter int FLEN   = FPRF_FLEN,
  parameter int NREGS  = 32,
  parameter int NRD    = 3,
  parameter int NWR    = FPRF_NWR,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS),
  localparam int PW    = NWR > 1 ? $clog2(NWR) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRD-1:0][AW-1:0]   rd_addr_i,
  output logic [NRD-1:0][FLEN-1:0] rd_data_o,
  output logic [NRD-1:0]           rd_pend_o,
  input  logic                     resv_vld_i,
  input  logic [AW-1:0]            resv_addr_i,
  input  logic [PW-1:0]            resv_port_i,
  output logic                     resv_rdy_o,
  input  logic [NWR-1:0]           wr_vld_i,
  input  logic [NWR-1:0][AW-1:0]   wr_addr_i,
  input  logic [NWR-1:0][FLEN-1:0] wr_data_i,
  input  logic                     flush_i,
  output logic                     busy_o
);
  logic [NREGS-1:0][FLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           pend, clr;
  scr1_pipe_fprf_scb #(.NREGS(NREGS), .NWR(NWR), .AW(AW), .PW(PW)) u_scb (
    .clk        (clk),
    .rst        (rst),
    .resv_vld_i (resv_vld_i),
    .resv_addr_i(resv_addr_i),
    .resv_port_i(resv_port_i),
    .wr_vld_i   (wr_vld_i),
    .wr_addr_i  (wr_addr_i),
    .flush_i    (flush_i),
    .resv_rdy_o (resv_rdy_o),
    .pend_o     (pend),
    .clr_o      (clr),
    .busy_o     (busy_o)
  );
  // walk ports high to low so the lowest index wins on address collisions
  always_comb begin
    regs_d = regs_q;
    for (int p = NWR - 1; p >= 0; p--)
      if (wr_vld_i[p]) regs_d[wr_addr_i[p]] = wr_data_i[p];
  end
  always_comb begin
    rd_data_o = '0;
    rd_pend_o = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data_o[i] = regs_q[rd_addr_i[i]];
      rd_pend_o[i] = pend[rd_addr_i[i]] && !(BYPASS != 0 && clr[rd_addr_i[i]]);
      for (int p = NWR - 1; p >= 0; p--)
        if (BYPASS != 0 && wr_vld_i[p] && wr_addr_i[p] == rd_addr_i[i]) rd_data_o[i] = wr_data_i[p];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
endmodule

// File: tb/tb_scr1_pipe_fprf_mp.sv
// tb_scr1_pipe_fprf_mp: vector table plus async-reset sequence, bypass and non-bypass instances side by side
module tb_scr1_pipe_fprf_mp;
  import scr1_fprf_pkg::*;
  typedef struct {
    string      nm;
    logic       rv;
    fprf_addr_t ra;
    logic       rp;
    logic       fl;
    logic [1:0] wv;
    fprf_addr_t wa0;
    fprf_data_t wd0;
    fprf_addr_t wa1;
    fprf_data_t wd1;
    fprf_addr_t rd;
    fprf_data_t eb;
    fprf_data_t en;
    logic       pb;
    logic       pn;
    logic       rdy;
    logic       busy;
  } vec_t;
  logic clk = 0, rst = 1;
  logic [2:0][4:0]  rd_addr;
  logic [2:0][31:0] dat_b, dat_n;
  logic [2:0]       pnd_b, pnd_n;
  logic             rv, rp, fl, rdy_b, rdy_n, busy_b, busy_n;
  logic [4:0]       ra;
  logic [1:0]       wv;
  logic [1:0][4:0]  wa;
  logic [1:0][31:0] wd;
  int n_cmp = 0, n_err = 0;
  vec_t tbl[$];
  vec_t exp_q[$];
  always #5 clk = ~clk;
  scr1_pipe_fprf_mp #(.BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(dat_b), .rd_pend_o(pnd_b),
    .resv_vld_i(rv), .resv_addr_i(ra), .resv_port_i(rp), .resv_rdy_o(rdy_b),
    .wr_vld_i(wv), .wr_addr_i(wa), .wr_data_i(wd), .flush_i(fl), .busy_o(busy_b));
  scr1_pipe_fprf_mp #(.BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(dat_n), .rd_pend_o(pnd_n),
    .resv_vld_i(rv), .resv_addr_i(ra), .resv_port_i(rp), .resv_rdy_o(rdy_n),
    .wr_vld_i(wv), .wr_addr_i(wa), .wr_data_i(wd), .flush_i(fl), .busy_o(busy_n));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(string nm, logic rv_, logic [4:0] ra_, logic rp_, logic fl_, logic [1:0] wv_,
                              logic [4:0] wa0, logic [31:0] wd0, logic [4:0] wa1, logic [31:0] wd1,
                              logic [4:0] rd, logic [31:0] eb, logic [31:0] en, logic pb, logic pn,
                              logic rdy, logic busy);
    vec_t v;
    v.nm = nm; v.rv = rv_; v.ra = ra_; v.rp = rp_; v.fl = fl_; v.wv = wv_;
    v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1; v.rd = rd;
    v.eb = eb; v.en = en; v.pb = pb; v.pn = pn; v.rdy = rdy; v.busy = busy;
    return v;
  endfunction
  task automatic idle();
    rv = 0; ra = 0; rp = 0; fl = 0; wv = 0; wa = '0; wd = '0;
  endtask
  task automatic chk_ctl(input string nm, input logic p, input logic r, input logic b);
    for (int i = 0; i < 3; i++) begin
      chk({nm, "_pend_b"}, 32'(pnd_b[i]), 32'(p));
      chk({nm, "_pend_n"}, 32'(pnd_n[i]), 32'(p));
    end
    chk({nm, "_rdy_b"}, 32'(rdy_b), 32'(r));
    chk({nm, "_rdy_n"}, 32'(rdy_n), 32'(r));
    chk({nm, "_busy_b"}, 32'(busy_b), 32'(b));
    chk({nm, "_busy_n"}, 32'(busy_n), 32'(b));
  endtask
  initial begin
    vec_t v;
    //           name        rv ra rp fl wv    wa0 wd0           wa1 wd1           rd  bypass        no-bypass     pb pn rdy busy
    tbl.push_back(mk("f0_wr",    0, 0, 0, 0, 2'b01, 0, 32'h3F800000, 0, 32'h0,        0, 32'h3F800000, 32'h0,        0, 0, 1, 0));
    tbl.push_back(mk("f0_rd",    0, 0, 0, 0, 2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h3F800000, 32'h3F800000, 0, 0, 1, 0));
    tbl.push_back(mk("rsv_f5",   1, 5, 1, 0, 2'b00, 0, 32'h0,        0, 32'h0,        5, 32'h0,        32'h0,        0, 0, 1, 0));
    tbl.push_back(mk("f5_pend",  0, 5, 0, 0, 2'b00, 0, 32'h0,        0, 32'h0,        5, 32'h0,        32'h0,        1, 1, 0, 1));
    tbl.push_back(mk("f5_p0wr",  0, 5, 0, 0, 2'b01, 5, 32'h40000000, 0, 32'h0,        5, 32'h40000000, 32'h0,        1, 1, 0, 1));
    tbl.push_back(mk("f5_p1wr",  0, 5, 0, 0, 2'b10, 0, 32'h0,        5, 32'h40400000, 5, 32'h40400000, 32'h40000000, 0, 1, 0, 1));
    tbl.push_back(mk("f5_done",  0, 5, 0, 0, 2'b00, 0, 32'h0,        0, 32'h0,        5, 32'h40400000, 32'h40400000, 0, 0, 1, 0));
    tbl.push_back(mk("rsv_f7",   1, 7, 1, 0, 2'b00, 0, 32'h0,        0, 32'h0,        7, 32'h0,        32'h0,        0, 0, 1, 0));
    tbl.push_back(mk("f7_dual",  0, 7, 0, 0, 2'b11, 7, 32'h11111111, 7, 32'h22222222, 7, 32'h11111111, 32'h0,        0, 1, 0, 1));
    tbl.push_back(mk("f7_after", 0, 7, 0, 0, 2'b00, 0, 32'h0,        0, 32'h0,        7, 32'h11111111, 32'h11111111, 0, 0, 1, 0));
    tbl.push_back(mk("rsv_f3",   1, 3, 1, 0, 2'b00, 0, 32'h0,        0, 32'h0,        3, 32'h0,        32'h0,        0, 0, 1, 0));
    tbl.push_back(mk("rsv_f4",   1, 4, 0, 0, 2'b00, 0, 32'h0,        0, 32'h0,        3, 32'h0,        32'h0,        1, 1, 1, 1));
    tbl.push_back(mk("rsv_f9",   1, 9, 1, 0, 2'b00, 0, 32'h0,        0, 32'h0,        4, 32'h0,        32'h0,        1, 1, 1, 1));
    tbl.push_back(mk("flush",    1, 10,1, 1, 2'b01, 9, 32'hA5A5A5A5, 0, 32'h0,        9, 32'hA5A5A5A5, 32'h0,        1, 1, 0, 1));
    tbl.push_back(mk("post_fl",  0, 10,0, 0, 2'b00, 0, 32'h0,        0, 32'h0,        10,32'h0,        32'h0,        0, 0, 1, 0));
    tbl.push_back(mk("f9_data",  0, 3, 0, 0, 2'b00, 0, 32'h0,        0, 32'h0,        9, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 1, 0));
    tbl.push_back(mk("f2_wrrsv", 1, 2, 1, 0, 2'b10, 0, 32'h0,        2, 32'hDEADBEEF, 2, 32'hDEADBEEF, 32'h0,        0, 0, 1, 0));
    tbl.push_back(mk("f2_pend",  0, 2, 0, 0, 2'b00, 0, 32'h0,        0, 32'h0,        2, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 0, 1));
    tbl.push_back(mk("f2_clr",   0, 2, 0, 0, 2'b10, 0, 32'h0,        2, 32'hCAFEF00D, 2, 32'hCAFEF00D, 32'hDEADBEEF, 0, 1, 0, 1));
    tbl.push_back(mk("rsv_f5b",  1, 5, 1, 0, 2'b00, 0, 32'h0,        0, 32'h0,        5, 32'h40400000, 32'h40400000, 0, 0, 1, 0));
    idle();
    rd_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_data_b", dat_b[0], 32'h0);
    chk("rst_data_n", dat_n[0], 32'h0);
    chk_ctl("rst", 0, 1, 0);
    rst = 0;
    foreach (tbl[k]) begin
      @(negedge clk);
      v = tbl[k];
      rv = v.rv; ra = v.ra; rp = v.rp; fl = v.fl; wv = v.wv;
      wa[0] = v.wa0; wd[0] = v.wd0; wa[1] = v.wa1; wd[1] = v.wd1;
      rd_addr = {3{v.rd}};
      exp_q.push_back(v);
      #1;
      v = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
        chk({v.nm, "_data_b"}, dat_b[i], v.eb);
        chk({v.nm, "_data_n"}, dat_n[i], v.en);
        chk({v.nm, "_pend_b"}, 32'(pnd_b[i]), 32'(v.pb));
        chk({v.nm, "_pend_n"}, 32'(pnd_n[i]), 32'(v.pn));
      end
      chk({v.nm, "_rdy_b"}, 32'(rdy_b), 32'(v.rdy));
      chk({v.nm, "_rdy_n"}, 32'(rdy_n), 32'(v.rdy));
      chk({v.nm, "_busy_b"}, 32'(busy_b), 32'(v.busy));
      chk({v.nm, "_busy_n"}, 32'(busy_n), 32'(v.busy));
    end
    @(negedge clk);
    idle();
    ra = 5;
    rd_addr = {3{5'd5}};
    #1;
    chk_ctl("pre_arst", 1, 0, 1);
    chk("pre_arst_data", dat_b[0], 32'h40400000);
    #1 rst = 1;
    #1;
    chk_ctl("arst", 0, 1, 0);
    foreach (tbl[k]) begin
      rd_addr = {3{tbl[k].rd}};
      #0.1;
      chk("arst_data_b", dat_b[0], 32'h0);
      chk("arst_data_n", dat_n[2], 32'h0);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1;
    chk_ctl("post_arst", 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
